psram_arb_mc: RTL and testbench
===============================

# psram_arb_mc

Parametrised N-channel arbiter sitting between framebuffer clients (SPI-fed writer, video reader, future blitter/scaler ports) and the PSRAM memory-interface user port, in the PSRAM user clock domain. Replaces the fixed two-port read/write arbiter. Adds configurable channel count, fixed-priority or round-robin policy with an urgent-channel mask, and burst-beat tracking. Also adds command-gap enforcement and read-timeout recovery.

## Interface
- NCH, 4: number of client channels (2..8)
- ADDR_W, 21: PSRAM word address width
- DATA_W, 64: user data width; MASK_W = DATA_W/8
- BURST_BEATS, 4: data beats per command (read and write)
- CMD_GAP, 12: minimum cycles from one o_psram_cmd_en to the next (≥ BURST_BEATS+1)
- RD_TIMEOUT, 64: max cycles from read cmd_en to last read beat
- MODE, 1: 0 = fixed priority (lowest index wins), 1 = round-robin
- URGENT_MASK, 'b0001: channels set here beat all unset channels; policy applies within each class

Ports:
- i_clk  in  1  PSRAM user clock (clk_out of memory interface)
- i_rst_n  in  1  reset, asynchronous, active-low
- i_req  in  NCH  per-channel request, held with i_we/i_addr stable until o_gnt
- i_we  in  NCH  1 = write burst, 0 = read burst
- i_addr  in  NCH*ADDR_W  packed burst start addresses, channel k at [k*ADDR_W +: ADDR_W]
- i_wdata  in  NCH*DATA_W  packed write beats
- i_wmask  in  NCH*MASK_W  packed write masks (1 = byte masked)
- o_gnt  out  NCH  one-cycle grant pulse
- o_wpull  out  NCH  write beat pull strobe; channel advances to next beat the cycle after
- o_rdata  out  DATA_W  shared read data
- o_rvalid  out  NCH  read beat valid for owning channel
- o_err  out  1  sticky read-timeout flag, cleared only by reset
- o_psram_cmd  out  1  1 = write, 0 = read
- o_psram_cmd_en  out  1  command strobe
- o_psram_addr  out  ADDR_W
- o_psram_wr_data  out  DATA_W
- o_psram_data_mask  out  MASK_W
- i_psram_rd_data  in  DATA_W
- i_psram_rd_data_valid  in  1
- i_psram_init_calib  in  1  memory ready

## Operation
- States: INIT, IDLE, WBURST, RWAIT, GAP.
- INIT: wait for i_psram_init_calib=1, then IDLE. No grants in INIT.
- IDLE at cycle T with any i_req and calib=1: select owner.
  - Urgent class first if any urgent channel requests.
  - MODE 0: lowest index in class.
  - MODE 1: first requester at index > last_owner (wrapping) within class. last_owner reset value NCH-1, updated on every grant.
- Write: o_wpull[owner] high T..T+BURST_BEATS-1 (combinational from state/counter). Owner beat j sampled at T+j and registered to o_psram_wr_data/o_psram_data_mask at T+1+j.
- All o_psram_* outputs registered.
- At T+1: o_psram_cmd_en=1 for exactly 1 cycle, with o_psram_cmd=i_we[owner] and o_psram_addr=i_addr[owner] (sampled at T). o_gnt[owner]=1 same cycle.
- WBURST lasts until the last beat is issued, then GAP.
- Read: RWAIT counts i_psram_rd_data_valid beats.
  - Each beat registered: o_rdata=i_psram_rd_data, o_rvalid[owner]=1 one cycle later.
  - On beat BURST_BEATS go to GAP.
  - Valid beats outside RWAIT are dropped.
- GAP: stay until CMD_GAP cycles have elapsed since cmd_en, then IDLE (INIT if calib=0).
- Timeout: if RWAIT exceeds RD_TIMEOUT cycles since cmd_en, set o_err, abandon the burst (no further o_rvalid for it), go to GAP.
- calib dropping mid-burst: current burst completes; the next IDLE entry goes to INIT.
- Requests dropped before grant are legal; no grant is issued to a channel whose i_req=0 at T.
- Reset values: all outputs 0, state INIT, counters 0.
- Reset mid-burst: all outputs return to 0 asynchronously; the burst is abandoned.

## Timing
- Request-to-cmd_en latency: 1 cycle from IDLE (T to T+1).
- Back-to-back commands: exactly CMD_GAP cycles apart when requests are continuous.
- o_gnt, o_psram_cmd_en: single-cycle, coincident.
- o_rvalid: 1 cycle after i_psram_rd_data_valid.
- o_wpull: BURST_BEATS consecutive cycles starting at T.
- Counters sized clog2(max(CMD_GAP, RD_TIMEOUT)+1). Beat counter clog2(BURST_BEATS+1). No overflow possible.

## Test plan
- Calib held 0 for 100 cycles with i_req=4'b1111 -> no o_gnt, no cmd_en. Raise calib -> ch0 (urgent) granted 1 cycle after next IDLE.
- MODE 1, URGENT_MASK=0, i_req=4'b1110 continuous -> grant order 1,2,3,1,...; cmd_en spacing exactly 12 cycles.
- Write on ch2, addr 21'h0ABCDE, beats 64'h1..64'h4, mask 8'h00 -> cmd=1 with that addr at T+1; wr_data 1,2,3,4 on T+1..T+4; o_wpull[2] high T..T+3.
- Read on ch1, memory returns 4 valid beats 64'hA0..A3 after 9 cycles -> o_rvalid[1] pulses 4 times, each 1 cycle later, o_rdata matching; o_rvalid for other channels stays 0.
- Read with only 2 beats returned -> o_err=1 at cmd_en+65, arbiter back in IDLE after GAP; the next request is granted normally.
- Assert i_rst_n=0 mid-write beat 2 -> all outputs 0 immediately. After release, INIT until calib, last_owner=NCH-1 (MODE 1 first grant to ch0).

Source files
------------

// File: rtl/psram_arb_mc_if.sv
// psram_arb_mc_if: client request bus and PSRAM user-port bundle.
// slave = arbiter view, master = clients plus memory-interface view.
interface psram_arb_mc_if #(
    parameter int NCH    = 4,
    parameter int ADDR_W = 21,
    parameter int DATA_W = 64
);
    localparam int MASK_W = DATA_W / 8;

    logic [NCH-1:0]        i_req;
    logic [NCH-1:0]        i_we;
    logic [NCH*ADDR_W-1:0] i_addr;
    logic [NCH*DATA_W-1:0] i_wdata;
    logic [NCH*MASK_W-1:0] i_wmask;
    logic [NCH-1:0]        o_gnt;
    logic [NCH-1:0]        o_wpull;
    logic [DATA_W-1:0]     o_rdata;
    logic [NCH-1:0]        o_rvalid;
    logic                  o_err;
    logic                  o_psram_cmd;
    logic                  o_psram_cmd_en;
    logic [ADDR_W-1:0]     o_psram_addr;
    logic [DATA_W-1:0]     o_psram_wr_data;
    logic [MASK_W-1:0]     o_psram_data_mask;
    logic [DATA_W-1:0]     i_psram_rd_data;
    logic                  i_psram_rd_data_valid;
    logic                  i_psram_init_calib;

    modport slave (
        input  i_req, i_we, i_addr, i_wdata, i_wmask,
        input  i_psram_rd_data, i_psram_rd_data_valid,
        input  i_psram_init_calib,
        output o_gnt, o_wpull, o_rdata, o_rvalid, o_err,
        output o_psram_cmd, o_psram_cmd_en, o_psram_addr,
        output o_psram_wr_data, o_psram_data_mask
    );

    modport master (
        output i_req, i_we, i_addr, i_wdata, i_wmask,
        output i_psram_rd_data, i_psram_rd_data_valid,
        output i_psram_init_calib,
        input  o_gnt, o_wpull, o_rdata, o_rvalid, o_err,
        input  o_psram_cmd, o_psram_cmd_en, o_psram_addr,
        input  o_psram_wr_data, o_psram_data_mask
    );
endinterface

// File: rtl/psram_arb_mc.sv
// psram_arb_mc: N-channel PSRAM user-port arbiter with burst tracking,
// command-gap enforcement and read-timeout recovery.
module psram_arb_mc #(
    parameter int             NCH         = 4,
    parameter int             ADDR_W      = 21,
    parameter int             DATA_W      = 64,
    parameter int             BURST_BEATS = 4,
    parameter int             CMD_GAP     = 12,
    parameter int             RD_TIMEOUT  = 64,
    parameter int             MODE        = 1,
    parameter logic [NCH-1:0] URGENT_MASK = 1
) (
    input logic           i_clk,
    input logic           i_rst_n,
    psram_arb_mc_if.slave bus
);
    localparam int MASK_W = DATA_W / 8;
    localparam int IDX_W  = $clog2(NCH);
    localparam int CNT_MX = (CMD_GAP > RD_TIMEOUT) ? CMD_GAP : RD_TIMEOUT;
    localparam int CNT_W  = $clog2(CNT_MX + 1);
    localparam int BEAT_W = $clog2(BURST_BEATS + 1);

    typedef enum logic [2:0] {
        S_INIT,
        S_IDLE,
        S_WBURST,
        S_RWAIT,
        S_GAP
    } state_t;

    state_t            state_q, state_d;
    logic [IDX_W-1:0]  owner_q, owner_d;
    logic [IDX_W-1:0]  last_q, last_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d, cnt_nx;
    logic [BEAT_W-1:0] beat_q, beat_d;
    logic [NCH-1:0]    gnt_q, gnt_d;
    logic              cmd_q, cmd_d;
    logic              cmd_en_q, cmd_en_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdat_q, wdat_d;
    logic [MASK_W-1:0] wmsk_q, wmsk_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic [NCH-1:0]    rvalid_q, rvalid_d;
    logic              err_q, err_d;
    logic [NCH-1:0]    wpull;
    logic              pull;
    logic [IDX_W-1:0]  pull_idx;

    logic [ADDR_W-1:0] addr_a [NCH];
    logic [DATA_W-1:0] wdat_a [NCH];
    logic [MASK_W-1:0] wmsk_a [NCH];

    for (genvar k = 0; k < NCH; k++) begin : g_unpack
        assign addr_a[k] = bus.i_addr[k*ADDR_W +: ADDR_W];
        assign wdat_a[k] = bus.i_wdata[k*DATA_W +: DATA_W];
        assign wmsk_a[k] = bus.i_wmask[k*MASK_W +: MASK_W];
    end

    function automatic logic [NCH-1:0] oh(input logic [IDX_W-1:0] i);
        oh    = '0;
        oh[i] = 1'b1;
    endfunction

    logic [NCH-1:0]   urg, cls;
    logic             sel_ok;
    logic [IDX_W-1:0] sel;
    logic [IDX_W:0]   j;

    // Urgent requesters shadow the rest; policy then picks within the class.
    always_comb begin
        urg    = bus.i_req & URGENT_MASK;
        cls    = (|urg) ? urg : bus.i_req;
        sel_ok = |cls;
        sel    = '0;
        j      = '0;
        if (MODE == 0) begin
            for (int i = NCH - 1; i >= 0; i--) begin
                if (cls[i]) sel = IDX_W'(i);
            end
        end else begin
            for (int i = NCH; i >= 1; i--) begin
                j = {1'b0, last_q} + (IDX_W+1)'(i);
                if (j >= (IDX_W+1)'(NCH)) j = j - (IDX_W+1)'(NCH);
                if (cls[j[IDX_W-1:0]]) sel = j[IDX_W-1:0];
            end
        end
    end

    assign cnt_nx = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;

    always_comb begin
        state_d  = state_q;
        owner_d  = owner_q;
        last_d   = last_q;
        cnt_d    = cnt_q;
        beat_d   = beat_q;
        gnt_d    = '0;
        cmd_d    = cmd_q;
        cmd_en_d = 1'b0;
        addr_d   = addr_q;
        wdat_d   = wdat_q;
        wmsk_d   = wmsk_q;
        rdata_d  = rdata_q;
        rvalid_d = '0;
        err_d    = err_q;
        wpull    = '0;
        pull     = 1'b0;
        pull_idx = owner_q;
        unique case (state_q)
            S_INIT: begin
                if (bus.i_psram_init_calib) state_d = S_IDLE;
            end
            S_IDLE: begin
                if (!bus.i_psram_init_calib) begin
                    state_d = S_INIT;
                end else if (sel_ok) begin
                    owner_d  = sel;
                    last_d   = sel;
                    gnt_d    = oh(sel);
                    cmd_en_d = 1'b1;
                    cmd_d    = bus.i_we[sel];
                    addr_d   = addr_a[sel];
                    cnt_d    = '0;
                    beat_d   = '0;
                    if (bus.i_we[sel]) begin
                        pull     = 1'b1;
                        pull_idx = sel;
                        beat_d   = BEAT_W'(1);
                        state_d  = (BURST_BEATS == 1) ? S_GAP : S_WBURST;
                    end else begin
                        state_d = S_RWAIT;
                    end
                end
            end
            S_WBURST: begin
                cnt_d  = cnt_nx;
                pull   = 1'b1;
                beat_d = beat_q + 1'b1;
                if (beat_q == BEAT_W'(BURST_BEATS - 1)) state_d = S_GAP;
            end
            S_RWAIT: begin
                cnt_d = cnt_nx;
                if (bus.i_psram_rd_data_valid) begin
                    rdata_d  = bus.i_psram_rd_data;
                    rvalid_d = oh(owner_q);
                    beat_d   = beat_q + 1'b1;
                end
                // A last beat landing on the deadline cycle still completes.
                if (bus.i_psram_rd_data_valid &&
                    beat_q == BEAT_W'(BURST_BEATS - 1)) begin
                    state_d = S_GAP;
                end else if (cnt_q >= CNT_W'(RD_TIMEOUT)) begin
                    err_d   = 1'b1;
                    state_d = S_GAP;
                end
            end
            S_GAP: begin
                cnt_d = cnt_nx;
                if (cnt_q >= CNT_W'(CMD_GAP - 2)) begin
                    state_d = bus.i_psram_init_calib ? S_IDLE : S_INIT;
                end
            end
            default: state_d = S_INIT;
        endcase
        if (pull) begin
            wpull  = oh(pull_idx);
            wdat_d = wdat_a[pull_idx];
            wmsk_d = wmsk_a[pull_idx];
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q  <= S_INIT;
            owner_q  <= '0;
            last_q   <= IDX_W'(NCH - 1);
            cnt_q    <= '0;
            beat_q   <= '0;
            gnt_q    <= '0;
            cmd_q    <= 1'b0;
            cmd_en_q <= 1'b0;
            addr_q   <= '0;
            wdat_q   <= '0;
            wmsk_q   <= '0;
            rdata_q  <= '0;
            rvalid_q <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            owner_q  <= owner_d;
            last_q   <= last_d;
            cnt_q    <= cnt_d;
            beat_q   <= beat_d;
            gnt_q    <= gnt_d;
            cmd_q    <= cmd_d;
            cmd_en_q <= cmd_en_d;
            addr_q   <= addr_d;
            wdat_q   <= wdat_d;
            wmsk_q   <= wmsk_d;
            rdata_q  <= rdata_d;
            rvalid_q <= rvalid_d;
            err_q    <= err_d;
        end
    end

    assign bus.o_gnt             = gnt_q;
    assign bus.o_wpull           = wpull;
    assign bus.o_rdata           = rdata_q;
    assign bus.o_rvalid          = rvalid_q;
    assign bus.o_err             = err_q;
    assign bus.o_psram_cmd       = cmd_q;
    assign bus.o_psram_cmd_en    = cmd_en_q;
    assign bus.o_psram_addr      = addr_q;
    assign bus.o_psram_wr_data   = wdat_q;
    assign bus.o_psram_data_mask = wmsk_q;
endmodule

// File: tb/tb_psram_arb_mc.sv
// tb_psram_arb_mc: directed checks of grant policy, write/read bursts,
// read timeout and asynchronous reset for psram_arb_mc.
module tb_psram_arb_mc;
    localparam int NCH = 4;
    localparam int AW  = 21;
    localparam int DW  = 64;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    psram_arb_mc_if #(.NCH(NCH), .ADDR_W(AW), .DATA_W(DW)) bus ();

    psram_arb_mc #(
        .NCH(NCH), .ADDR_W(AW), .DATA_W(DW), .BURST_BEATS(4),
        .CMD_GAP(12), .RD_TIMEOUT(64), .MODE(1),
        .URGENT_MASK(4'b0001)
    ) dut (
        .i_clk  (clk),
        .i_rst_n(rst_n),
        .bus    (bus)
    );

    int cyc  = 0;
    int nchk = 0;
    int nerr = 0;
    int widx [NCH];

    // Client write FIFOs: beat j of any channel is j+1, advanced on pull.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        for (int k = 0; k < NCH; k++)
            widx[k] <= bus.o_wpull[k] ? widx[k] + 1 : 0;
    end

    always_comb begin
        bus.i_wdata = '0;
        for (int k = 0; k < NCH; k++)
            bus.i_wdata[k*DW +: DW] = 64'(widx[k]) + 64'd1;
    end

    typedef struct {
        logic [3:0] req;
        int         ch;
    } rr_t;

    rr_t vec [9];
    logic [AW-1:0] atab [NCH];

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic wait_gnt(output int ch, output int at);
        bit done;
        ch   = -1;
        at   = -1;
        done = 1'b0;
        for (int n = 0; n < 200 && !done; n++) begin
            @(negedge clk);
            if (bus.o_gnt != 0) begin
                done = 1'b1;
                at   = cyc;
                ch   = -2;
                for (int k = 0; k < NCH; k++)
                    if (bus.o_gnt == (4'b0001 << k)) ch = k;
                check("gnt_with_cmd_en", 64'(bus.o_psram_cmd_en), 1);
            end
        end
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_gnt"}, 64'(bus.o_gnt), 0);
        check({tag, "_cmd_en"}, 64'(bus.o_psram_cmd_en), 0);
        check({tag, "_cmd"}, 64'(bus.o_psram_cmd), 0);
        check({tag, "_addr"}, 64'(bus.o_psram_addr), 0);
        check({tag, "_wdata"}, bus.o_psram_wr_data, 0);
        check({tag, "_mask"}, 64'(bus.o_psram_data_mask), 0);
        check({tag, "_wpull"}, 64'(bus.o_wpull), 0);
        check({tag, "_rvalid"}, 64'(bus.o_rvalid), 0);
        check({tag, "_rdata"}, bus.o_rdata, 0);
        check({tag, "_err"}, 64'(bus.o_err), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int ch, at, t0, prev, bad, rvc, errn, gn;
        logic [3:0] gv;

        vec[0] = '{4'b1110, 1};
        vec[1] = '{4'b1110, 2};
        vec[2] = '{4'b1110, 3};
        vec[3] = '{4'b1110, 1};
        vec[4] = '{4'b1010, 3};
        vec[5] = '{4'b1011, 0};
        vec[6] = '{4'b1010, 1};
        vec[7] = '{4'b1100, 2};
        vec[8] = '{4'b0110, 1};
        atab[0] = 21'h000100;
        atab[1] = 21'h012345;
        atab[2] = 21'h0ABCDE;
        atab[3] = 21'h1F0F0F;

        bus.i_req = '0;
        bus.i_we = '0;
        bus.i_wmask = '0;
        bus.i_psram_rd_data = '0;
        bus.i_psram_rd_data_valid = 1'b0;
        bus.i_psram_init_calib = 1'b0;
        for (int k = 0; k < NCH; k++) bus.i_addr[k*AW +: AW] = atab[k];

        repeat (2) @(negedge clk);
        check_zero("reset");
        rst_n = 1'b1;

        // Calibration held low: no grants at all.
        bus.i_req = 4'b1111;
        bus.i_we = 4'b1111;
        bad = 0;
        repeat (100) begin
            @(negedge clk);
            if (bus.o_gnt != 0 || bus.o_psram_cmd_en) bad++;
        end
        check("calib0_no_gnt", 64'(bad), 0);
        bus.i_psram_init_calib = 1'b1;
        t0 = cyc;
        wait_gnt(ch, at);
        check("calib_urgent_ch", 64'(ch), 0);
        check("calib_gnt_latency", 64'(at - t0), 2);
        check("calib_addr", 64'(bus.o_psram_addr), 64'(atab[0]));
        check("calib_cmd", 64'(bus.o_psram_cmd), 1);
        prev = at;

        // Round-robin / urgent table with continuous requests.
        for (int v = 0; v < 9; v++) begin
            bus.i_req = vec[v].req;
            wait_gnt(ch, at);
            check("rr_ch", 64'(ch), 64'(vec[v].ch));
            check("rr_addr", 64'(bus.o_psram_addr), 64'(atab[vec[v].ch]));
            check("rr_spacing", 64'(at - prev), 12);
            prev = at;
        end
        bus.i_req = '0;
        repeat (15) @(negedge clk);

        // Write burst on ch2.
        bus.i_we = 4'b0100;
        bus.i_req = 4'b0100;
        #1;
        check("wr_wpull_T", 64'(bus.o_wpull), 4'b0100);
        check("wr_no_gnt_T", 64'(bus.o_gnt), 0);
        for (int jj = 1; jj <= 4; jj++) begin
            @(negedge clk);
            check("wr_wdata", bus.o_psram_wr_data, 64'(jj));
            check("wr_wpull", 64'(bus.o_wpull), (jj < 4) ? 4'b0100 : 4'b0000);
            check("wr_cmd_en", 64'(bus.o_psram_cmd_en), (jj == 1) ? 1 : 0);
            if (jj == 1) begin
                check("wr_gnt", 64'(bus.o_gnt), 4'b0100);
                check("wr_cmd", 64'(bus.o_psram_cmd), 1);
                check("wr_addr", 64'(bus.o_psram_addr), 64'h0ABCDE);
                check("wr_mask", 64'(bus.o_psram_data_mask), 0);
                bus.i_req = '0;
            end
        end
        repeat (15) @(negedge clk);

        // Read burst on ch1, four beats after a latency.
        bus.i_we = '0;
        bus.i_req = 4'b0010;
        wait_gnt(ch, at);
        check("rd_ch", 64'(ch), 1);
        check("rd_cmd", 64'(bus.o_psram_cmd), 0);
        check("rd_addr", 64'(bus.o_psram_addr), 64'h012345);
        bus.i_req = '0;
        repeat (8) @(negedge clk);
        for (int b = 0; b < 4; b++) begin
            bus.i_psram_rd_data_valid = 1'b1;
            bus.i_psram_rd_data = 64'hA0 + 64'(b);
            @(negedge clk);
            check("rd_rvalid", 64'(bus.o_rvalid), 4'b0010);
            check("rd_rdata", bus.o_rdata, 64'hA0 + 64'(b));
        end
        bus.i_psram_rd_data_valid = 1'b0;
        @(negedge clk);
        check("rd_rvalid_end", 64'(bus.o_rvalid), 0);
        bus.i_psram_rd_data_valid = 1'b1;
        bus.i_psram_rd_data = 64'hFF;
        @(negedge clk);
        bus.i_psram_rd_data_valid = 1'b0;
        check("stray_rvalid", 64'(bus.o_rvalid), 0);
        check("stray_rdata", bus.o_rdata, 64'hA3);
        check("rd_err", 64'(bus.o_err), 0);
        repeat (15) @(negedge clk);

        // Read on ch3 with only two beats returned: timeout.
        bus.i_req = 4'b1000;
        wait_gnt(ch, at);
        check("to_ch", 64'(ch), 3);
        bus.i_req = '0;
        rvc = 0;
        errn = -1;
        gn = -1;
        gv = '0;
        for (int n = 1; n <= 70; n++) begin
            bus.i_psram_rd_data_valid = (n == 3 || n == 4);
            bus.i_psram_rd_data = 64'hB0 + 64'(n);
            @(negedge clk);
            if (bus.o_rvalid != 0) rvc++;
            if (bus.o_err && errn < 0) errn = n;
            if (bus.o_gnt != 0 && gn < 0) begin
                gn = n;
                gv = bus.o_gnt;
                bus.i_req = '0;
            end
            if (n == 65) begin
                bus.i_we = 4'b0010;
                bus.i_req = 4'b0010;
            end
        end
        bus.i_psram_rd_data_valid = 1'b0;
        check("to_rvalid_count", 64'(rvc), 2);
        check("to_err_cycle", 64'(errn), 65);
        check("to_next_gnt_cycle", 64'(gn), 67);
        check("to_next_gnt_ch", 64'(gv), 4'b0010);
        check("to_err_sticky", 64'(bus.o_err), 1);
        repeat (15) @(negedge clk);

        // Asynchronous reset during beat 2 of a ch2 write.
        bus.i_we = 4'b0100;
        bus.i_req = 4'b0100;
        @(negedge clk);
        check("rst_pre_gnt", 64'(bus.o_gnt), 4'b0100);
        bus.i_req = '0;
        @(negedge clk);
        check("rst_pre_wdata", bus.o_psram_wr_data, 2);
        #2;
        rst_n = 1'b0;
        bus.i_psram_init_calib = 1'b0;
        #1;
        check_zero("midrst");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        bus.i_we = 4'b1110;
        bus.i_req = 4'b1110;
        bad = 0;
        repeat (10) begin
            @(negedge clk);
            if (bus.o_gnt != 0 || bus.o_psram_cmd_en) bad++;
        end
        check("post_rst_no_gnt", 64'(bad), 0);
        bus.i_psram_init_calib = 1'b1;
        t0 = cyc;
        wait_gnt(ch, at);
        check("post_rst_rr_ch", 64'(ch), 1);
        check("post_rst_latency", 64'(at - t0), 2);
        bus.i_req = '0;
        repeat (15) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end
endmodule
